seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment vectors are ordered {a,b,c,d,e,f,g} with a at bit 6 and stored
// active-low, so a 0 bit lights that segment.
package seg7_pkg;

    // All segments dark in the active-low encoding.
    localparam logic [6:0] SEG_OFF = 7'b111_1111;

    // Hex nibble to segment pattern, active-low, a at MSB.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b000_0001,  // 0
        7'b100_1111,  // 1
        7'b001_0010,  // 2
        7'b000_0110,  // 3
        7'b100_1100,  // 4
        7'b010_0100,  // 5
        7'b010_0000,  // 6
        7'b000_1111,  // 7
        7'b000_0000,  // 8
        7'b000_0100,  // 9
        7'b000_1000,  // A
        7'b110_0000,  // b
        7'b011_0001,  // C
        7'b100_0010,  // d
        7'b011_0000,  // E
        7'b011_1000   // F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment decoder (active-low, a at MSB).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment display driver.
// A prescaler produces one tick per digit slot; the digit index steps on each
// tick. New display data is staged by load and only copied into the active
// registers at a frame wrap, so a frame never shows a mix of old and new data.
// AN/CA/DP are registered and follow the index with one cycle of latency.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 125000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [NUM_DIGITS-1:0]     AN,
    output logic [6:0]                CA,
    output logic                      DP,
    output logic                      frame_done,
    output logic                      load_ack
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Internal logic works in active-low; INV flips everything at the pins
    // when the board wants active-high drive.
    localparam logic INV = (ACTIVE_LOW == 0);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{~INV}};
    localparam logic [6:0]            CA_IDLE = SEG_OFF ^ {7{INV}};
    localparam logic                  DP_IDLE = ~INV;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] stg_digits_q, stg_digits_d;
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              ca_q, ca_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;
    logic                    load_ack_q, load_ack_d;

    logic                    tick;
    logic                    wrap;
    logic                    commit;
    logic [3:0]              cur_nibble;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              ca_n;
    logic                    dp_n;

    // Nibble of the digit currently being scanned, taken from active data only.
    assign cur_nibble = act_digits_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg_n  (seg_n)
    );

    // Next-state logic: prescaler, index, staging/commit and output encoding.
    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        wrap   = tick && (idx_q == IDX_LAST);
        commit = wrap && pending_q;

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        // Staging always takes the newest load; a load on the wrap edge is
        // staged here while the commit below still sees the old staging data.
        stg_digits_d = stg_digits_q;
        stg_dp_d     = stg_dp_q;
        stg_blank_d  = stg_blank_q;
        if (load) begin
            stg_digits_d = digits_in;
            stg_dp_d     = dp_in;
            stg_blank_d  = blank_in;
        end
        pending_d = load | (pending_q & ~commit);

        act_digits_d = act_digits_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        if (commit) begin
            act_digits_d = stg_digits_q;
            act_dp_d     = stg_dp_q;
            act_blank_d  = stg_blank_q;
        end

        frame_done_d = wrap;
        load_ack_d   = commit;

        // Active-low pin image for the current slot; a blanked slot stays dark.
        an_n = '1;
        ca_n = SEG_OFF;
        dp_n = 1'b1;
        if (!act_blank_q[idx_q]) begin
            an_n[idx_q] = 1'b0;
            ca_n        = seg_n;
            dp_n        = ~act_dp_q[idx_q];
        end
        an_d = an_n ^ {NUM_DIGITS{INV}};
        ca_d = ca_n ^ {7{INV}};
        dp_d = dp_n ^ INV;
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            stg_digits_q <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '1;
            act_digits_q <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            an_q         <= AN_IDLE;
            ca_q         <= CA_IDLE;
            dp_q         <= DP_IDLE;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            stg_digits_q <= stg_digits_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            act_digits_q <= act_digits_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            an_q         <= an_d;
            ca_q         <= ca_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign AN         = an_q;
    assign CA         = ca_q;
    assign DP         = dp_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: 4 digits, 3 clocks per slot.
// Stimulus pushes the expected {AN,CA,DP} of every slot of each frame into
// exp_q as the frame starts; a monitor pops one entry whenever the display
// changes, and also checks slot length, frame period and load_ack count.
// A second instance with active-high polarity is checked directly.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 3;
    localparam logic [11:0] OFF_T = {4'b1111, 7'b111_1111, 1'b1};

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (active-low)
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  an;
    logic [6:0]  ca;
    logic        dp;
    logic        frame_done;
    logic        load_ack;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .AN         (an),
        .CA         (ca),
        .DP         (dp),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    // Polarity DUT (active-high)
    logic        p_load = 1'b0;
    logic [15:0] p_digits = '0;
    logic [3:0]  p_dp = '0;
    logic [3:0]  p_blank = '0;
    logic [3:0]  p_an;
    logic [6:0]  p_ca;
    logic        p_dpo;
    logic        p_frame_done;
    logic        p_load_ack;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(0)) dut_pol (
        .clk        (clk),
        .reset      (reset),
        .load       (p_load),
        .digits_in  (p_digits),
        .dp_in      (p_dp),
        .blank_in   (p_blank),
        .AN         (p_an),
        .CA         (p_ca),
        .DP         (p_dpo),
        .frame_done (p_frame_done),
        .load_ack   (p_load_ack)
    );

    // Lit segments (active-high, order a..g) for hex 0..F
    logic [6:0] seg_on [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Scoreboard
    logic [11:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    bit mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_slot(input int d, input logic [15:0] dg,
                                             input logic [3:0] dpv, input logic [3:0] bl);
        logic [3:0] nib;
        logic [3:0] an_v;
        if (bl[d]) return OFF_T;
        nib = dg[4*d +: 4];
        an_v = 4'b1111;
        an_v[d] = 1'b0;
        return {an_v, ~seg_on[nib], ~dpv[d]};
    endfunction

    // Wait for the next frame wrap, then queue the four slots of the frame to come.
    task automatic frame(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_wait", 32'(seen), 32'd1);
        for (int d = 0; d < ND; d++) exp_q.push_back(exp_slot(d, dg, dpv, bl));
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_load(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl);
        digits_in = dg;
        dp_in = dpv;
        blank_in = bl;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Monitor
    logic [11:0] prev_t = OFF_T;
    bit have_prev = 1'b0;
    bit fd_have = 1'b0;
    int run = 0;
    int fd_run = 0;

    always @(negedge clk) begin
        logic [11:0] cur;
        logic [11:0] e;
        cur = {an, ca, dp};
        if (reset) begin
            prev_t = OFF_T;
            have_prev = 1'b0;
            fd_have = 1'b0;
            run = 0;
            fd_run = 0;
        end else begin
            run++;
            fd_run++;
            if (cur !== prev_t) begin
                if (mon_en) begin
                    if (have_prev) begin
                        n_cmp++;
                        if (run != RD) begin
                            n_fail++;
                            $display("FAIL slot_hold: got %0d cycles expected %0d", run, RD);
                        end
                    end
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_change: got an=%b ca=%b dp=%b expected no change",
                                 an, ca, dp);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            n_fail++;
                            $display("FAIL display: got an=%b ca=%b dp=%b expected an=%b ca=%b dp=%b",
                                     an, ca, dp, e[11:8], e[7:1], e[0]);
                        end
                    end
                end
                have_prev = 1'b1;
                run = 0;
                prev_t = cur;
            end
            if (frame_done) begin
                if (fd_have && mon_en) begin
                    n_cmp++;
                    if (fd_run != ND * RD) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d cycles expected %0d", fd_run, ND * RD);
                    end
                end
                fd_have = 1'b1;
                fd_run = 0;
            end
            if (load_ack) ack_cnt++;
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int a0;
        int k;
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_ca", 32'(ca), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_load_ack", 32'(load_ack), 32'd0);
        check("rst_pol_an", 32'(p_an), 32'h0);
        check("rst_pol_ca", 32'(p_ca), 32'h0);
        check("rst_pol_dp", 32'(p_dpo), 32'd0);

        // Scan timing and decode: 4321, all digits lit
        reset = 1'b0;
        pulse_load(16'h4321, 4'b0000, 4'b0000);
        repeat (3) frame(16'h4321, 4'b0000, 4'b0000);
        check("ack_after_first_load", 32'(ack_cnt), 32'd1);

        // Two loads inside one frame: old data holds, newest commits at wrap
        frame(16'h4321, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        pulse_load(16'h00AB, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        pulse_load(16'h00CD, 4'b0000, 4'b0000);
        check("ack_before_wrap", 32'(ack_cnt), 32'd1);
        frame(16'h00CD, 4'b0000, 4'b0000);
        frame(16'h00CD, 4'b0000, 4'b0000);
        check("ack_single_for_two_loads", 32'(ack_cnt), 32'd2);

        // Blank digit 1, decimal point on digit 2
        pulse_load(16'h4321, 4'b0100, 4'b0010);
        frame(16'h4321, 4'b0100, 4'b0010);
        frame(16'h4321, 4'b0100, 4'b0010);
        drain();
        check("ack_after_blank_load", 32'(ack_cnt), 32'd3);

        // Reset during the digit-2 slot with a load pending
        frame(16'h4321, 4'b0100, 4'b0010);
        pulse_load(16'h9999, 4'b0000, 4'b0000);
        repeat (6) @(negedge clk);
        check("pre_reset_digit2_an", 32'(an), 32'hB);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_reset_an", 32'(an), 32'hF);
        check("mid_reset_ca", 32'(ca), 32'h7F);
        check("mid_reset_dp", 32'(dp), 32'd1);
        check("mid_reset_load_ack", 32'(load_ack), 32'd0);
        a0 = ack_cnt;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        k = 0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (frame_done) seen = 1'b1;
        end
        check("restart_first_frame_cycles", 32'(k), 32'(ND * RD));
        repeat (2) @(negedge clk);
        check("no_ack_after_reset", 32'(ack_cnt), 32'(a0));
        check("post_reset_dark_an", 32'(an), 32'hF);
        pulse_load(16'h4321, 4'b0000, 4'b0000);
        frame(16'h4321, 4'b0000, 4'b0000);
        frame(16'h4321, 4'b0000, 4'b0000);
        drain();
        check("ack_after_reset_reload", 32'(ack_cnt), 32'(a0 + 1));
        mon_en = 1'b0;

        // Active-high polarity: digit 0 = 8 with point, others blank
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge clk);
            if (p_frame_done) seen = 1'b1;
        end
        check("pol_align_wait", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        p_digits = 16'h0008;
        p_dp = 4'b0001;
        p_blank = 4'b1110;
        p_load = 1'b1;
        @(negedge clk);
        p_load = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge clk);
            if (p_frame_done) seen = 1'b1;
        end
        check("pol_frame_wait", 32'(seen), 32'd1);
        @(negedge clk);
        check("pol_digit0_an", 32'(p_an), 32'h1);
        check("pol_digit0_ca", 32'(p_ca), 32'h7F);
        check("pol_digit0_dp", 32'(p_dpo), 32'd1);
        repeat (3) @(negedge clk);
        check("pol_blank_an", 32'(p_an), 32'h0);
        check("pol_blank_ca", 32'(p_ca), 32'h0);
        check("pol_blank_dp", 32'(p_dpo), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
